// File: rtl/rom_arbiter.sv
// Two-port arbiter that shares one slow asynchronous ROM between instruction fetch (A) and data load (B).
// Define ROM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority with A ahead of B.
module rom_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  // state | meaning
  // IDLE  | no transaction; a request is granted here
  // WAIT  | rom_address held while the ROM access time elapses
  // DONE  | ack pulse for the granted port; never grants
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       sel_b;
  logic       grant_b;

`ifdef ROM_ARB_RR_EN
  logic rr_b;   // high when B has priority on the next contended grant

  always_comb begin
    grant_b = ~a_req;
    if (a_req && b_req) grant_b = rr_b;
  end
`else
  always_comb begin
    grant_b = ~a_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sel_b       <= 1'b0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      busy        <= 1'b0;
      rom_address <= '0;
      rd_data     <= '0;
`ifdef ROM_ARB_RR_EN
      rr_b        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          if (a_req || b_req) begin
            sel_b       <= grant_b;
            rom_address <= grant_b ? b_addr : a_addr;
            cnt         <= 4'(WAIT_CYCLES - 1);
            busy        <= 1'b1;
            state       <= WAIT;
`ifdef ROM_ARB_RR_EN
            rr_b        <= ~grant_b;
`endif
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            rd_data <= rom_data;
            a_ack   <= ~sel_b;
            b_ack   <= sel_b;
            state   <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
